// File: rtl/fdivsqrt_sched_if.sv
// Handshake bundle between issue logic, writeback and the divsqrt sequencer.
// The slave modport is the sequencer side; the master modport is the issue/writeback side.
interface fdivsqrt_sched_if #(parameter int CNTW = 5);
   logic            flush_i;
   logic            fp_valid_i;
   logic            fp_special_i;
   logic            fp_ready_o;
   logic            int_valid_i;
   logic            int_zero_i;
   logic            int_ready_o;
   logic            init_o;
   logic            iter_en_o;
   logic            owner_o;
   logic [CNTW-1:0] cnt_o;
   logic            busy_o;
   logic            done_valid_o;
   logic            done_ready_i;

   modport master (
      output flush_i, fp_valid_i, fp_special_i, int_valid_i, int_zero_i, done_ready_i,
      input  fp_ready_o, int_ready_o, init_o, iter_en_o, owner_o, cnt_o, busy_o, done_valid_o
   );

   modport slave (
      input  flush_i, fp_valid_i, fp_special_i, int_valid_i, int_zero_i, done_ready_i,
      output fp_ready_o, int_ready_o, init_o, iter_en_o, owner_o, cnt_o, busy_o, done_valid_o
   );
endinterface

// File: rtl/fdivsqrt_sched.sv
// Sequencer/arbiter for the shared iterative divide/sqrt datapath.
// Define IDIV_ON_FPU_EN to enable the integer requester and round-robin arbitration.
module fdivsqrt_sched #(
   parameter int FP_ITERS  = 14,
   parameter int INT_ITERS = 17,
   parameter int CNTW      = 5
) (
   input logic            clk,
   input logic            reset_n,
   fdivsqrt_sched_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd2} state_t;

   localparam logic [CNTW-1:0] FP_LOAD  = CNTW'(FP_ITERS - 1);
   localparam logic [CNTW-1:0] INT_LOAD = CNTW'(INT_ITERS - 1);

   state_t          state, state_nxt;
   logic [CNTW-1:0] cnt;
   logic            owner;
   logic            grant_int;
   logic            idle_open;
   logic            fp_rdy, int_rdy;
   logic            accept;
   logic            special;

   // Gated by reset_n so the combinational handshakes also read 0 during reset.
   assign idle_open = reset_n & (state == IDLE) & ~bus.flush_i;

`ifdef IDIV_ON_FPU_EN
   logic rr;  // 0 = FP side favoured on a tie, 1 = integer side

   assign grant_int = bus.int_valid_i & (~bus.fp_valid_i | rr);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    rr <= 1'b0;
      else if (accept) rr <= ~grant_int;
   end
`else
   logic unused_int;

   assign grant_int  = 1'b0;
   assign unused_int = bus.int_valid_i ^ bus.int_zero_i;
`endif

   assign fp_rdy  = idle_open & bus.fp_valid_i & ~grant_int;
   assign int_rdy = idle_open & grant_int;
   assign accept  = fp_rdy | int_rdy;
   assign special = grant_int ? bus.int_zero_i : bus.fp_special_i;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = special ? DONE : ITER;
         ITER: begin
            if (bus.flush_i)   state_nxt = IDLE;
            else if (cnt == '0) state_nxt = DONE;
         end
         DONE: if (bus.flush_i || bus.done_ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // cnt saturates at 0: the last step happens with cnt==0 and then leaves ITER.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt   <= '0;
         owner <= 1'b0;
      end else if (accept) begin
         owner <= grant_int;
         cnt   <= special ? '0 : (grant_int ? INT_LOAD : FP_LOAD);
      end else if (state == ITER) begin
         if (bus.flush_i)     cnt <= '0;
         else if (cnt != '0)  cnt <= cnt - 1'b1;
      end
   end

   assign bus.fp_ready_o   = fp_rdy;
   assign bus.int_ready_o  = int_rdy;
   assign bus.init_o       = accept;
   assign bus.iter_en_o    = (state == ITER);
   assign bus.busy_o       = (state != IDLE);
   assign bus.done_valid_o = (state == DONE);
   assign bus.owner_o      = owner;
   assign bus.cnt_o        = cnt;
endmodule

// File: tb/tb_fdivsqrt_sched.sv
// Directed table-driven bench for fdivsqrt_sched plus flush, done-hold and reset sequences.
// Expectations follow IDIV_ON_FPU_EN the same way the design does.
module tb_fdivsqrt_sched;
`ifdef IDIV_ON_FPU_EN
   localparam bit INT_EN = 1'b1;
`else
   localparam bit INT_EN = 1'b0;
`endif
   localparam int FPI  = 14;
   localparam int INTI = 17;

   typedef struct {
      bit fv, fs, iv, iz;   // stimulus
      bit fr, ir;           // expected ready
      bit own;              // expected owner
      int iters;            // expected iter_en cycles (done at iters+1)
   } vec_t;

   logic clk = 1'b0;
   logic reset_n;
   int   n_vec = 0;
   int   n_err = 0;
   vec_t vecs[8];

   fdivsqrt_sched_if #(.CNTW(5)) bus();

   fdivsqrt_sched #(.FP_ITERS(FPI), .INT_ITERS(INTI), .CNTW(5)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic clr_in();
      bus.flush_i = 0; bus.fp_valid_i = 0; bus.fp_special_i = 0;
      bus.int_valid_i = 0; bus.int_zero_i = 0; bus.done_ready_i = 0;
   endtask

   task automatic do_reset();
      reset_n = 0;
      clr_in();
      repeat (2) @(negedge clk);
      reset_n = 1;
   endtask

   // Returns the cycle (relative to accept = 0) at which done_valid_o is first seen, 0 on timeout.
   task automatic wait_done(output int done_c, output int iters);
      done_c = 0; iters = 0;
      for (int c = 1; c <= 60 && done_c == 0; c++) begin
         @(negedge clk);
         if (bus.iter_en_o)    iters++;
         if (bus.done_valid_o) done_c = c;
      end
   endtask

   task automatic take_done();
      bus.done_ready_i = 1;
      @(posedge clk); #1;
      bus.done_ready_i = 0;
      @(negedge clk);
   endtask

   task automatic run_vec(input int k, input vec_t v);
      int done_c, iters;
      @(negedge clk);
      bus.fp_valid_i = v.fv; bus.fp_special_i = v.fs;
      bus.int_valid_i = v.iv; bus.int_zero_i = v.iz;
      #1;
      chk($sformatf("v%0d fp_ready", k), bus.fp_ready_o, v.fr);
      chk($sformatf("v%0d int_ready", k), bus.int_ready_o, v.ir);
      chk($sformatf("v%0d init", k), bus.init_o, v.fr | v.ir);
      @(posedge clk); #1;
      clr_in();
      if (!(v.fr | v.ir)) begin
         @(negedge clk);
         chk($sformatf("v%0d idle busy", k), bus.busy_o, 0);
      end else begin
         wait_done(done_c, iters);
         chk($sformatf("v%0d iters", k), iters, v.iters);
         chk($sformatf("v%0d done cycle", k), done_c, v.iters + 1);
         chk($sformatf("v%0d owner", k), bus.owner_o, v.own);
         if (done_c != 0) begin
            take_done();
            chk($sformatf("v%0d busy after done", k), bus.busy_o, 0);
         end
      end
   endtask

   function automatic vec_t mk(bit fv, bit fs, bit iv, bit iz, bit fr, bit ir, bit own, int iters);
      vec_t v;
      v.fv = fv; v.fs = fs; v.iv = iv; v.iz = iz;
      v.fr = fr; v.ir = ir; v.own = own; v.iters = iters;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int done_c, iters, bad_dv, bad_own, bad_rdy;

      // rr pointer walks FP -> INT -> FP ... on each accept when enabled
      vecs[0] = mk(1, 0, 0, 0, 1, 0, 0, FPI);
      vecs[1] = mk(1, 0, 1, 0, !INT_EN, INT_EN, INT_EN, INT_EN ? INTI : FPI);
      vecs[2] = mk(1, 0, 1, 0, 1, 0, 0, FPI);
      vecs[3] = mk(1, 0, 1, 0, !INT_EN, INT_EN, INT_EN, INT_EN ? INTI : FPI);
      vecs[4] = mk(0, 0, 1, 1, 0, INT_EN, INT_EN, 0);
      vecs[5] = mk(1, 1, 0, 0, 1, 0, 0, 0);
      vecs[6] = mk(0, 0, 1, 0, 0, INT_EN, INT_EN, INT_EN ? INTI : 0);
      vecs[7] = mk(1, 0, 0, 1, 1, 0, 0, FPI);

      // Reset state, with requests pending to show readies are gated
      reset_n = 0;
      clr_in();
      bus.fp_valid_i = 1; bus.int_valid_i = 1;
      #2;
      chk("reset outputs", {bus.fp_ready_o, bus.int_ready_o, bus.init_o, bus.iter_en_o,
                            bus.busy_o, bus.done_valid_o, bus.owner_o, bus.cnt_o}, 0);
      do_reset();

      foreach (vecs[k]) run_vec(k, vecs[k]);

      // Flush at cycle 5 of ITER, new FP accepted at cycle 6
      do_reset();
      bus.fp_valid_i = 1;
      @(posedge clk); #1;
      bus.fp_valid_i = 0;
      @(negedge clk);
      chk("flush cnt at cycle 1", bus.cnt_o, FPI - 1);
      repeat (4) @(negedge clk);
      chk("flush iter_en cycle 5", bus.iter_en_o, 1);
      bus.flush_i = 1; bus.fp_valid_i = 1;
      #1;
      chk("flush ready blocked", bus.fp_ready_o, 0);
      @(posedge clk); #1;
      bus.flush_i = 0;
      @(negedge clk);
      chk("flush idle cycle 6", {bus.busy_o, bus.done_valid_o}, 0);
      chk("flush reaccept init", {bus.fp_ready_o, bus.init_o}, 2'b11);
      @(posedge clk); #1;
      bus.fp_valid_i = 0;
      wait_done(done_c, iters);
      chk("flush new op done cycle", done_c, FPI + 1);
      chk("flush new op iters", iters, FPI);

      // Flush while in DONE drops the result
      bus.flush_i = 1;
      @(posedge clk); #1;
      bus.flush_i = 0;
      @(negedge clk);
      chk("flush in done", {bus.busy_o, bus.done_valid_o}, 0);

      // done_ready_i held low for 10 cycles in DONE
      do_reset();
      bus.fp_valid_i = 1;
      @(posedge clk); #1;
      bus.fp_valid_i = 0;
      wait_done(done_c, iters);
      chk("hold reached done", done_c, FPI + 1);
      bus.fp_valid_i = 1; bus.int_valid_i = 1;
      bad_dv = 0; bad_own = 0; bad_rdy = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.done_valid_o !== 1'b1) bad_dv++;
         if (bus.owner_o !== 1'b0) bad_own++;
         if ({bus.fp_ready_o, bus.int_ready_o} !== 2'b00) bad_rdy++;
      end
      chk("hold done_valid stable", bad_dv, 0);
      chk("hold owner stable", bad_own, 0);
      chk("hold readies low", bad_rdy, 0);
      bus.done_ready_i = 1;
      #1;
      chk("no accept with done_ready", {bus.fp_ready_o, bus.int_ready_o, bus.init_o}, 0);
      @(posedge clk); #1;
      clr_in();
      @(negedge clk);
      chk("idle after done_ready", {bus.busy_o, bus.done_valid_o}, 0);

      // reset_n pulsed during ITER; rr pointer must return to FP
      do_reset();
      bus.fp_valid_i = 1; bus.int_valid_i = 1;
      #1;
      chk("rst seq first grant fp", {bus.fp_ready_o, bus.int_ready_o}, 2'b10);
      @(posedge clk); #1;
      clr_in();
      repeat (7) @(negedge clk);
      chk("rst seq cnt at cycle 7", bus.cnt_o, 7);
      reset_n = 0;
      bus.fp_valid_i = 1; bus.int_valid_i = 1;
      #1;
      chk("mid-op reset outputs", {bus.fp_ready_o, bus.int_ready_o, bus.init_o, bus.iter_en_o,
                                   bus.busy_o, bus.done_valid_o, bus.owner_o, bus.cnt_o}, 0);
      @(negedge clk);
      reset_n = 1;
      #1;
      chk("post-reset grant fp", {bus.fp_ready_o, bus.int_ready_o}, 2'b10);
      @(posedge clk); #1;
      clr_in();
      @(negedge clk);
      chk("post-reset owner busy", {bus.owner_o, bus.busy_o, bus.iter_en_o}, 3'b011);
      wait_done(done_c, iters);
      chk("post-reset done cycle", done_c + 1, FPI + 1);
      if (done_c != 0) take_done();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/fdivsqrt_sched.md
# fdivsqrt_sched

Sequencer/arbiter for the shared iterative divide/square-root datapath. Accepts FP divide/sqrt and integer divide/remainder requests, arbitrates round-robin when both are pending and pulses the datapath's operand-load strobe. It then steps the datapath for a fixed iteration count and holds a result-valid handshake until the writeback stage takes the result. It sits between the FPU/IEU issue logic and the radix/copies-configured divsqrt iteration unit.

## Interface
- FP_ITERS, default 14: iteration cycles for an FP operation (FPDUR of the configured core).
- INT_ITERS, default 17: iteration cycles for an integer operation.
- CNTW, default 5: counter width; must satisfy 2^CNTW > max(FP_ITERS, INT_ITERS).
- clk  in  1  core clock; all state updates on rising edge.
- reset_n  in  1  reset; asynchronous and active-low.
- flush_i  in  1  pipeline flush; kills any operation in flight.
- fp_valid_i  in  1  FP request pending.
- fp_special_i  in  1  FP operands special (NaN/Inf/zero); no iterations needed.
- fp_ready_o  out  1  FP request accepted this cycle when high with fp_valid_i.
- int_valid_i  in  1  integer request pending.
- int_zero_i  in  1  integer divisor is zero; no iterations needed.
- int_ready_o  out  1  integer request accepted this cycle when high with int_valid_i.
- init_o  out  1  datapath operand-load strobe (equals the accept cycle).
- iter_en_o  out  1  datapath iteration step enable.
- owner_o  out  1  current owner: 0 = FP, 1 = integer; valid from accept through DONE.
- cnt_o  out  CNTW  remaining iterations minus one while iterating.
- busy_o  out  1  high in any state other than IDLE.
- done_valid_o  out  1  result valid for owner_o.
- done_ready_i  in  1  writeback accepts result.

## Operation
- States: IDLE, ITER, DONE. Reset: IDLE, cnt=0, owner=0, rr pointer=FP. All outputs are 0 during reset.
- IDLE: if flush_i=0, grant goes to the single valid requester. If both requesters are valid, grant goes to the rr pointer's side. Only the granted requester sees ready_o=1; the other sees 0.
- Accept (valid & ready): init_o=1 the same cycle. owner latched, and rr pointer set to the non-granted side.
- After accept, if the special flag is set (fp_special_i for FP, int_zero_i for integer), the next state is DONE.
- Otherwise the next state is ITER, with cnt loaded to ITERS-1 for the owner.
- ITER: iter_en_o=1 every cycle, and cnt decrements each cycle. When cnt==0 the step still occurs and the next state is DONE.
- DONE: done_valid_o=1 and held stable (owner unchanged) until done_ready_i. On done_ready_i the next state is IDLE. No new accept occurs in the same cycle.
- flush_i in any state: next state IDLE, and no done_valid_o is produced for the killed op. In IDLE, flush_i forces both ready_o to 0. Flush takes precedence over accept, cnt==0 and done_ready_i.
- cnt never wraps; it is decremented only in ITER with cnt>0.
- reset_n low mid-operation: immediate return to reset values; rr pointer returns to FP.

## Timing
- Accept in cycle 0. iter_en_o is high in cycles 1..N, where N = FP_ITERS or INT_ITERS. done_valid_o rises in cycle N+1.
- Special/zero case: done_valid_o in cycle 1, and iter_en_o is never asserted.
- ready_o and init_o are combinational from state, valids and flush. done_valid_o, iter_en_o, busy_o, owner_o and cnt_o are functions of registered state only.
- Minimum back-to-back spacing: done accepted in cycle k, next accept no earlier than cycle k+1.

## Configuration
- IDIV_ON_FPU_EN defined: integer requester active, with round-robin arbitration as above.
- IDIV_ON_FPU_EN undefined: integer ports remain present but are ignored. int_ready_o tied 0, owner_o tied 0, and the rr pointer is removed; the FP requester is always granted when valid.

## Test plan
- FP only, FP_ITERS=14, fp_special_i=0: accept cycle 0, iter_en_o high 14 cycles, done_valid_o cycle 15. With done_ready_i=1, busy_o falls cycle 16.
- Both valid in IDLE after reset: FP granted first (owner_o=0). On the next IDLE, integer is granted (owner_o=1, INT_ITERS=17 → done cycle 18). Alternation continues while both remain valid.
- int_zero_i=1 on accept: done_valid_o cycle 1, iter_en_o never high, owner_o=1.
- flush_i asserted at cycle 5 of ITER: state IDLE at cycle 6, done_valid_o never asserted, and a new FP request is accepted at cycle 6.
- done_ready_i held 0 for 10 cycles in DONE: done_valid_o and owner_o stable, both ready_o low. done_ready_i=1 → IDLE next cycle.
- reset_n pulsed low during ITER (cnt=7): all outputs 0 immediately. After release, both valid → FP granted.
